// File: rtl/bram_pkg.sv
// bram_pkg: shared state type, constants and width helpers for the BRAM write path.
// Consumers: bram_burst_writer (optional feature macro BRAM_BURST_WRITER_PIPE_EN).
package bram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic [127:0] BRAM_WE_ALL = '1;

  function automatic int words_per_beat(
    input int din_w,
    input int bram_w
  );
    return din_w / bram_w;
  endfunction

  function automatic bit params_ok(
    input int din_w,
    input int bram_w
  );
    return (bram_w > 0) &&
           (bram_w % 8 == 0) &&
           (din_w % bram_w == 0) &&
           (din_w / bram_w >= 2);
  endfunction

endpackage

// File: rtl/bram_burst_writer_if.sv
// bram_burst_writer_if: wide-beat valid/ready write channel.
// master drives beats, slave (the writer) returns ready.
interface bram_burst_writer_if #(
  parameter int DATA_IN_WIDTH = 512
);
  logic                     wr_valid_i;
  logic [DATA_IN_WIDTH-1:0] wr_data_i;
  logic                     wr_ready_o;

  modport master (
    output wr_valid_i,
    output wr_data_i,
    input  wr_ready_o
  );

  modport slave (
    input  wr_valid_i,
    input  wr_data_i,
    output wr_ready_o
  );
endinterface

// File: rtl/wide_to_word_shifter.sv
// wide_to_word_shifter: holds one wide beat and presents it
// one narrow word at a time, least-significant word first.
module wide_to_word_shifter #(
  parameter int W_IN  = 512,
  parameter int W_OUT = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             shift,
  input  logic [W_IN-1:0]  din,
  output logic [W_OUT-1:0] dout
);

  logic [W_IN-1:0] sh_q;

  // load has priority so a reload on the last word replaces the shift
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= din;
    end else if (shift) begin
      sh_q <= sh_q >> W_OUT;
    end
  end

  assign dout = sh_q[W_OUT-1:0];

endmodule

// File: rtl/bram_burst_writer.sv
// bram_burst_writer: splits wide beats into BRAM words written to consecutive addresses.
// Optional macro BRAM_BURST_WRITER_PIPE_EN: accept the next beat on the last-word cycle.
module bram_burst_writer
  import bram_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 13,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int DATA_IN_WIDTH   = 512
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         addr_load_i,
  input  logic [ADDRESS_WIDTH-1:0]     addr_start_i,
  bram_burst_writer_if.slave           wr,
  output logic                         busy_o,
  output logic                         beat_done_o,
  output logic                         wrap_o,
  output logic [ADDRESS_WIDTH-1:0]     bram_addr,
  output logic                         bram_en,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_we,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_data_in
);

  localparam int WORDS = words_per_beat(DATA_IN_WIDTH, BRAM_DATA_WIDTH);
  localparam int CW    = $clog2(WORDS);
  localparam int WE_W  = BRAM_DATA_WIDTH / 8;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  if (!params_ok(DATA_IN_WIDTH, BRAM_DATA_WIDTH)) begin : g_param_err
    $error("bram_burst_writer: DATA_IN_WIDTH/BRAM_DATA_WIDTH invalid");
  end

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     in_wr;
  logic                     wr_go;
  logic                     last;
  logic                     ready;
  logic                     hs;
  logic                     sh_load;
  logic                     sh_shift;

  assign in_wr = (state_q == WRITE);
  assign wr_go = in_wr & en_i;
  assign last  = wr_go & (cnt_q == LAST);

`ifdef BRAM_BURST_WRITER_PIPE_EN
  assign ready = (~in_wr & en_i & ~addr_load_i) | last;
`else
  assign ready = ~in_wr & en_i & ~addr_load_i;
`endif

  assign hs            = wr.wr_valid_i & ready;
  assign wr.wr_ready_o = ready;

  // state, write pointer and word counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state; en_i low freezes everything, load beats a pending beat
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (en_i & addr_load_i) begin
          ptr_d = addr_start_i;
        end else if (hs) begin
          sh_load = 1'b1;
          cnt_d   = '0;
          state_d = WRITE;
        end
      end
      (state_q == WRITE): begin
        if (wr_go) begin
          ptr_d    = ptr_q + 1'b1;
          sh_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (last) begin
            if (hs) begin
              sh_load = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: ;
    endcase
  end

  wide_to_word_shifter #(
    .W_IN  (DATA_IN_WIDTH),
    .W_OUT (BRAM_DATA_WIDTH)
  ) u_shift (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (wr.wr_data_i),
    .dout  (bram_data_in)
  );

  assign busy_o      = in_wr;
  assign beat_done_o = last;
  assign wrap_o      = wr_go & (&ptr_q);
  assign bram_addr   = ptr_q;
  assign bram_en     = wr_go;
  assign bram_we     = wr_go ? BRAM_WE_ALL[WE_W-1:0] : '0;

endmodule

// File: tb/tb_bram_burst_writer.sv
// tb_bram_burst_writer: randomized beats checked against a word-list model
// of the writer (address, data, flags and cycle of every BRAM write).
module tb_bram_burst_writer;

  localparam int AW    = 13;
  localparam int BW    = 32;
  localparam int DW    = 512;
  localparam int WORDS = DW / BW;
`ifdef BRAM_BURST_WRITER_PIPE_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  typedef struct packed {
    logic [31:0]     cyc;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   data;
    logic [BW/8-1:0] we;
    logic            done;
    logic            wrap;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            addr_load;
  logic [AW-1:0]   addr_start;
  logic            busy;
  logic            beat_done;
  logic            wrap;
  logic [AW-1:0]   bram_addr;
  logic            bram_en;
  logic [BW/8-1:0] bram_we;
  logic [BW-1:0]   bram_data_in;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  wr_t got[$];
  wr_t exp_q[$];
  int  hs_q[$];

  bram_burst_writer_if #(.DATA_IN_WIDTH(DW)) bus();

  bram_burst_writer #(
    .ADDRESS_WIDTH   (AW),
    .BRAM_DATA_WIDTH (BW),
    .DATA_IN_WIDTH   (DW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .addr_load_i  (addr_load),
    .addr_start_i (addr_start),
    .wr           (bus),
    .busy_o       (busy),
    .beat_done_o  (beat_done),
    .wrap_o       (wrap),
    .bram_addr    (bram_addr),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .bram_data_in (bram_data_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_en)
      got.push_back('{cyc, bram_addr, bram_data_in, bram_we, beat_done, wrap});
    if (bus.wr_valid_i && bus.wr_ready_o)
      hs_q.push_back(cyc);
  end

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] b;
    for (int i = 0; i < WORDS; i++) b[i*BW +: BW] = $urandom;
    return b;
  endfunction

  function automatic void model_beat(input logic [AW-1:0] start,
                                     input logic [DW-1:0] beat,
                                     input int first);
    for (int k = 0; k < WORDS; k++) begin
      wr_t w;
      w.cyc  = first + k;
      w.addr = AW'((int'(start) + k) % (1 << AW));
      w.data = beat[k*BW +: BW];
      w.we   = '1;
      w.done = (k == WORDS - 1);
      w.wrap = (int'(w.addr) == (1 << AW) - 1);
      exp_q.push_back(w);
    end
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    got.delete();
    exp_q.delete();
    hs_q.delete();
  endtask

  task automatic send_beat(input logic [DW-1:0] beat, output bit timeout);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = beat;
    timeout = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.wr_ready_o) begin
        timeout = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.wr_valid_i = 1'b0;
    bus.wr_data_i  = rand_beat();
  endtask

  task automatic load_addr(input logic [AW-1:0] a);
    addr_load  = 1'b1;
    addr_start = a;
    step();
    addr_load  = 1'b0;
  endtask

  function automatic int first_cyc();
    return (hs_q.size() > 0) ? hs_q[0] + 1 : -1000;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; addr_load = 1'b0; addr_start = '0;
    bus.wr_valid_i = 1'b0; bus.wr_data_i = '0;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bram_en, bram_we, bram_addr, busy, beat_done, wrap} !== '0) begin
      errors++;
      $display("FAIL reset_outs got en=%b we=%h a=%h busy=%b done=%b wrap=%b exp all 0",
               bram_en, bram_we, bram_addr, busy, beat_done, wrap);
    end
    checks++;
    if (bram_data_in !== '0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", bram_data_in);
    end
    checks++;
    if (bus.wr_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", bus.wr_ready_o);
    end
    en = 1'b0;
    #1;
    checks++;
    if (bus.wr_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_en0 got %b exp 0", bus.wr_ready_o);
    end
    en = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [DW-1:0] b;
    bit to;
    clear();
    for (int k = 0; k < WORDS; k++) b[k*BW +: BW] = 32'(k * 17);
    send_beat(b, to);
    step(20);
    model_beat('0, b, first_cyc());
    checks++;
    if (to || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count got %0d exp %0d to=%b", got.size(), exp_q.size(), to);
    end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL single_wr[%0d] got %p exp %p", k, got[k], exp_q[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.wr_ready_o !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got rdy=%b busy=%b exp 1 0", bus.wr_ready_o, busy);
    end
    step();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] b;
    bit to;
    int nwrap;
    clear();
    b = rand_beat();
    load_addr(13'h1FF8);
    send_beat(b, to);
    step(20);
    model_beat(13'h1FF8, b, first_cyc());
    checks++;
    if (to || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count got %0d exp %0d to=%b", got.size(), exp_q.size(), to);
    end
    nwrap = 0;
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      nwrap += int'(got[k].wrap);
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL wrap_wr[%0d] got %p exp %p", k, got[k], exp_q[k]);
      end
    end
    checks++;
    if (nwrap != 1) begin
      errors++;
      $display("FAIL wrap_once got %0d exp 1", nwrap);
    end
  endtask

  task automatic test_pause();
    logic [DW-1:0] b;
    logic [AW-1:0] a;
    bit to;
    clear();
    b = rand_beat();
    a = AW'($urandom_range(0, (1 << AW) - 1));
    load_addr(a);
    send_beat(b, to);
    step(6);
    en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bram_en !== 1'b0 || busy !== 1'b1 || bram_we !== '0) begin
        errors++;
        $display("FAIL pause_hold got en=%b busy=%b we=%h exp 0 1 0", bram_en, busy, bram_we);
      end
      step();
    end
    en = 1'b1;
    step(20);
    model_beat(a, b, first_cyc());
    for (int k = 6; k < exp_q.size(); k++) exp_q[k].cyc = exp_q[k].cyc + 3;
    checks++;
    if (to || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL pause_count got %0d exp %0d to=%b", got.size(), exp_q.size(), to);
    end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL pause_wr[%0d] got %p exp %p", k, got[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] b0, b1;
    bit to0, to1;
    int f;
    clear();
    b0 = rand_beat();
    b1 = rand_beat();
    load_addr('0);
    send_beat(b0, to0);
    send_beat(b1, to1);
    step(40);
    f = first_cyc();
    model_beat('0, b0, f);
    model_beat(AW'(WORDS), b1, f + WORDS + GAP);
    checks++;
    if (to0 || to1 || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d exp %0d to=%b%b", got.size(), exp_q.size(), to0, to1);
    end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL b2b_wr[%0d] got %p exp %p", k, got[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_load();
    logic [DW-1:0] b;
    logic [AW-1:0] a;
    bit to;
    int lc;
    clear();
    b = rand_beat();
    a = AW'($urandom_range(0, (1 << AW) - 1));
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = b;
    addr_load  = 1'b1;
    addr_start = a;
    @(negedge clk);
    lc = cyc;
    checks++;
    if (bus.wr_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL load_ready got %b exp 0", bus.wr_ready_o);
    end
    step();
    addr_load = 1'b0;
    send_beat(b, to);
    addr_load  = 1'b1;
    addr_start = ~a;
    step(5);
    addr_load = 1'b0;
    step(20);
    checks++;
    if (hs_q.size() == 0 || hs_q[0] != lc + 1) begin
      errors++;
      $display("FAIL load_hs_cyc got %0d exp %0d", first_cyc() - 1, lc + 1);
    end
    model_beat(a, b, lc + 2);
    checks++;
    if (to || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL load_count got %0d exp %0d to=%b", got.size(), exp_q.size(), to);
    end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL load_wr[%0d] got %p exp %p", k, got[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] b;
    logic [AW-1:0] a;
    bit to;
    clear();
    b = rand_beat();
    a = AW'($urandom_range(1, (1 << AW) - 1));
    load_addr(a);
    send_beat(b, to);
    step(8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bram_en !== 1'b0 || bram_addr !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outs got en=%b a=%h busy=%b exp 0 0 0", bram_en, bram_addr, busy);
    end
    step(20);
    model_beat(a, b, first_cyc());
    while (exp_q.size() > 9) void'(exp_q.pop_back());
    checks++;
    if (to || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rstmid_count got %0d exp %0d to=%b", got.size(), exp_q.size(), to);
    end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL rstmid_wr[%0d] got %p exp %p", k, got[k], exp_q[k]);
      end
    end
    clear();
    b = rand_beat();
    send_beat(b, to);
    step(20);
    model_beat('0, b, first_cyc());
    checks++;
    if (to || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rstmid_fresh_count got %0d exp %0d to=%b", got.size(), exp_q.size(), to);
    end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL rstmid_fresh_wr[%0d] got %p exp %p", k, got[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_pause();
    test_back_to_back();
    test_load();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
